comparador_secuencial: RTL and testbench

Sequential, bit-serial magnitude comparator that time-multiplexes a single comparison cell over two N-bit unsigned words, scanning MSB to LSB. It is the controlled, one-cell-per-cycle counterpart of the combinational iterative comparison network. A start/done handshake sequences the comparison, and latched P/Q state carries the decision between cycles. It sits between a requester, which presents A/B and pulses `start`, and logic that consumes `Zout`.

---
 rtl/comparador_pkg.sv | 14 +
 rtl/celda_serie.sv | 22 ++
 rtl/comparador_secuencial.sv | 101 ++++++++++
 tb/tb_comparador_secuencial.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/comparador_pkg.sv
// Shared definitions for the bit-serial magnitude comparator: controller states and P/Q encoding.
package comparador_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARA = 2'd1,
    FIN     = 2'd2
  } estado_t;

  localparam logic [1:0] PQ_IGUAL = 2'b00;
  localparam logic [1:0] PQ_MAYOR = 2'b10;
  localparam logic [1:0] PQ_MENOR = 2'b01;

endpackage

// File: rtl/celda_serie.sv
// One comparison cell: once a decision (P/Q != 00) exists it is held, otherwise bit i decides.
module celda_serie
  import comparador_pkg::*;
(
  input  logic p,
  input  logic q,
  input  logic Ai,
  input  logic Bi,
  output logic P,
  output logic Q
);

  always_comb begin
    P = p;
    Q = q;
    if ({p, q} == PQ_IGUAL) begin
      P = Ai & ~Bi;
      Q = ~Ai & Bi;
    end
  end

endmodule

// File: rtl/comparador_secuencial.sv
// Bit-serial MSB-first unsigned comparator with start/done handshake.
// Optional early exit on first differing bit: define COMPARADOR_SALIDA_TEMPRANA_EN.
module comparador_secuencial
  import comparador_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic         Zout,
  output logic         iguales
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  estado_t          state;
  logic [N-1:0]     a_reg;
  logic [N-1:0]     b_reg;
  logic [1:0]       pq;
  logic [1:0]       pq_next;
  logic [IDX_W-1:0] idx;
  logic             fin_now;

  celda_serie u_celda (
    .p  (pq[1]),
    .q  (pq[0]),
    .Ai (a_reg[idx]),
    .Bi (b_reg[idx]),
    .P  (pq_next[1]),
    .Q  (pq_next[0])
  );

  // Decision is taken on the cell output so the exit costs no extra cycle.
`ifdef COMPARADOR_SALIDA_TEMPRANA_EN
  assign fin_now = (idx == '0) || (pq_next != PQ_IGUAL);
`else
  assign fin_now = (idx == '0);
`endif

  // Operand capture is pure data and carries no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      a_reg <= A;
      b_reg <= B;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      Zout    <= 1'b0;
      iguales <= 1'b0;
      pq      <= PQ_IGUAL;
      idx     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pq    <= PQ_IGUAL;
            idx   <= IDX_W'(N - 1);
            state <= COMPARA;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end
        COMPARA: begin
          pq <= pq_next;
          if (fin_now) begin
            state   <= FIN;
            busy    <= 1'b0;
            done    <= 1'b1;
            Zout    <= pq_next[1];
            iguales <= ~pq_next[1] & ~pq_next[0];
          end else begin
            idx <= idx - 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparador_secuencial.sv
// Self-checking bench for comparador_secuencial (N=3 and N=8 instances), both macro builds.
module tb_comparador_secuencial;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start3 = 1'b0;
  logic [2:0] a3 = '0, b3 = '0;
  logic       ready3, busy3, done3, zout3, ig3;
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ready8, busy8, done8, zout8, ig8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  comparador_secuencial #(.N(3)) dut (
    .clk(clk), .rst(rst), .start(start3), .A(a3), .B(b3),
    .ready(ready3), .busy(busy3), .done(done3), .Zout(zout3), .iguales(ig3)
  );

  comparador_secuencial #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
    .ready(ready8), .busy(busy8), .done(done8), .Zout(zout8), .iguales(ig8)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Cycle (counted from the accepting edge) at which done is seen.
  function automatic int exp_lat(input int a, input int b, input int n);
`ifdef COMPARADOR_SALIDA_TEMPRANA_EN
    for (int j = n - 1; j >= 0; j--)
      if (((a >> j) & 1) != ((b >> j) & 1)) return n - j + 1;
`endif
    return n + 1;
  endfunction

  task automatic run3(input int a, input int b);
    int at, ndone, z, ig;
    at = -1; ndone = 0; z = -1; ig = -1;
    @(negedge clk);
    a3 = 3'(a); b3 = 3'(b); start3 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start3 = 1'b0;
      a3 = 3'($urandom_range(0, 7));
      b3 = 3'($urandom_range(0, 7));
      if (done3) begin
        ndone++;
        if (at < 0) begin
          at = k; z = int'(zout3); ig = int'(ig3);
        end
      end
    end
    check($sformatf("lat_%0d_%0d", a, b), at, exp_lat(a, b, 3));
    check($sformatf("ndone_%0d_%0d", a, b), ndone, 1);
    check($sformatf("zout_%0d_%0d", a, b), z, (a > b) ? 1 : 0);
    check($sformatf("iguales_%0d_%0d", a, b), ig, (a == b) ? 1 : 0);
    check($sformatf("zout_hold_%0d_%0d", a, b), int'(zout3), (a > b) ? 1 : 0);
  endtask

  initial begin
    int ndone, z, period, lat8;
    int pos[$];

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", int'(ready3), 1);
    check("rst_busy", int'(busy3), 0);
    check("rst_done", int'(done3), 0);
    check("rst_zout", int'(zout3), 0);
    check("rst_iguales", int'(ig3), 0);
    check("rst_ready8", int'(ready8), 1);

    // Directed cases
    run3(5, 3);
    run3(2, 6);
    run3(7, 7);
    run3(0, 0);
    run3(7, 0);
    run3(0, 7);

    // Random cases
    for (int i = 0; i < 24; i++) run3(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));

    // start while busy/FIN is ignored
    ndone = 0; z = -1;
    @(negedge clk);
    a3 = 3'd4; b3 = 3'd1; start3 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 2) begin
        start3 = 1'b1; a3 = 3'd0; b3 = 3'd7;
      end else begin
        start3 = 1'b0;
      end
      if (done3) begin
        ndone++; z = int'(zout3);
      end
    end
    check("ignore_ndone", ndone, 1);
    check("ignore_zout", z, 1);
    run3(3, 5);

    // Reset mid-operation aborts
    run3(6, 2);
    ndone = 0;
    @(negedge clk);
    a3 = 3'd1; b3 = 3'd0; start3 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start3 = 1'b0;
      if (k == 2) rst = 1'b1;
      if (k == 3) begin
        rst = 1'b0;
        check("abort_ready", int'(ready3), 1);
        check("abort_busy", int'(busy3), 0);
        check("abort_zout", int'(zout3), 0);
        check("abort_iguales", int'(ig3), 0);
      end
      if (done3) ndone++;
    end
    check("abort_ndone", ndone, 0);

    // rst and start together: request lost
    ndone = 0;
    @(negedge clk);
    rst = 1'b1; start3 = 1'b1; a3 = 3'd5; b3 = 3'd3;
    @(negedge clk);
    rst = 1'b0; start3 = 1'b0;
    check("rststart_busy", int'(busy3), 0);
    check("rststart_ready", int'(ready3), 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done3) ndone++;
    end
    check("rststart_ndone", ndone, 0);
    run3(5, 3);

    // N=8 back-to-back with start held high
    lat8 = exp_lat(8'h80, 8'h7F, 8);
    period = lat8 + 1;
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h7F; start8 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (done8) begin
        pos.push_back(k);
        check($sformatf("n8_zout_%0d", k), int'(zout8), 1);
        check($sformatf("n8_iguales_%0d", k), int'(ig8), 0);
      end
    end
    start8 = 1'b0;
    check("n8_count_min3", (pos.size() >= 3) ? 1 : 0, 1);
    check("n8_first_done", (pos.size() > 0) ? pos[0] : -1, lat8);
    check("n8_second_done", (pos.size() > 1) ? pos[1] : -1, lat8 + period);
    check("n8_third_done", (pos.size() > 2) ? pos[2] : -1, lat8 + 2 * period);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
